// File: rtl/disp_writer.sv
// disp_writer: downstream stage of the disparity calculator.
// Assigns a raster position to each disparity strobe. It buffers
// {address, disparity} pairs in a small show-ahead FIFO that absorbs RAM
// back-pressure, and it runs the per-frame IDLE/RUN/DRAIN/DONE sequence.
// Optional build macro DISP_MEDIAN3_EN: a 3-tap horizontal median filter is
// applied in-line (zero latency) to the value that is pushed.
module disp_writer #(
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 16,
  parameter int DW         = 6,
  parameter int AW         = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] d_in,
  input  logic          d_valid,
  input  logic          wr_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          frame_done,
  output logic          overflow,
  output logic [DW-1:0] max_d
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + DW;

  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
  localparam logic [AW-1:0] ROW_LEN = AW'(IMG_W);
  localparam logic [CW-1:0] CNT_MAX = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Median of three unsigned values: clamp c into [min(a,b), max(a,b)].
  function automatic logic [DW-1:0] med3(input logic [DW-1:0] a,
                                         input logic [DW-1:0] b,
                                         input logic [DW-1:0] c);
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    logic [DW-1:0] res;
    if (a < b) begin
      lo = a;
      hi = b;
    end else begin
      lo = b;
      hi = a;
    end
    if (c <= lo) begin
      res = lo;
    end else if (c >= hi) begin
      res = hi;
    end else begin
      res = c;
    end
    return res;
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [EW-1:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_busy;
  logic            r_frame_done;
  logic            r_overflow;
  logic [DW-1:0]   r_max_d;

  logic            w_start_frame;
  logic            w_accept_pix;
  logic            w_last_slot;
  logic            w_fifo_empty;
  logic            w_fifo_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [AW-1:0]   w_slot_addr;
  logic [DW-1:0]   w_pix;

  // Strobe qualification and FIFO handshake decode.
  always_comb begin
    w_start_frame = (r_state == S_IDLE) && start;
    w_accept_pix  = (r_state == S_RUN) && d_valid;
    w_last_slot   = (r_x == X_LAST) && (r_y == Y_LAST);
    w_fifo_empty  = (r_count == CW'(0));
    w_fifo_full   = (r_count == CNT_MAX);
    w_pop         = !w_fifo_empty && wr_ready;
    // A full FIFO can still take the pixel when the head leaves this cycle.
    w_push        = w_accept_pix && (!w_fifo_full || w_pop);
    w_drop        = w_accept_pix && !w_push;
    w_slot_addr   = (AW'(r_y) * ROW_LEN) + AW'(r_x);
  end

`ifdef DISP_MEDIAN3_EN
  logic [DW-1:0] r_h1;
  logic [DW-1:0] r_h2;

  // Filtered pixel: pass-through at row start, h2 replicated from h1 at x=1.
  always_comb begin
    if (r_x == XW'(0)) begin
      w_pix = d_in;
    end else if (r_x == XW'(1)) begin
      w_pix = med3(r_h1, r_h1, d_in);
    end else begin
      w_pix = med3(r_h2, r_h1, d_in);
    end
  end

  // Row history shifts on every RUN strobe, dropped pixels included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h1 <= {DW{1'b0}};
      r_h2 <= {DW{1'b0}};
    end else if (w_accept_pix) begin
      if (r_x == XW'(0)) begin
        r_h1 <= d_in;
        r_h2 <= d_in;
      end else begin
        r_h2 <= r_h1;
        r_h1 <= d_in;
      end
    end else begin
      r_h1 <= r_h1;
      r_h2 <= r_h2;
    end
  end
`else
  // Unfiltered build: the calculator output is written unchanged.
  always_comb begin
    w_pix = d_in;
  end
`endif

  // Frame state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame sequencing: start only in IDLE, drain the buffer before DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (d_valid && w_last_slot) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        if (w_fifo_empty) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Raster counters advance on every RUN strobe so drops keep alignment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x <= XW'(0);
      r_y <= YW'(0);
    end else if (w_start_frame) begin
      r_x <= XW'(0);
      r_y <= YW'(0);
    end else if (w_accept_pix) begin
      if (r_x == X_LAST) begin
        r_x <= XW'(0);
        if (r_y == Y_LAST) begin
          r_y <= YW'(0);
        end else begin
          r_y <= r_y + YW'(1);
        end
      end else begin
        r_x <= r_x + XW'(1);
        r_y <= r_y;
      end
    end else begin
      r_x <= r_x;
      r_y <= r_y;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_slot_addr, w_pix};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= PW'(0);
      r_rd_ptr <= PW'(0);
      r_count  <= CW'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame status: sticky overflow and running maximum, cleared at frame start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_max_d    <= {DW{1'b0}};
    end else if (w_start_frame) begin
      r_overflow <= 1'b0;
      r_max_d    <= {DW{1'b0}};
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else begin
        r_overflow <= r_overflow;
      end
      if (w_push && (w_pix > r_max_d)) begin
        r_max_d <= w_pix;
      end else begin
        r_max_d <= r_max_d;
      end
    end
  end

  // Registered busy / frame_done flags, aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_busy       <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
      r_frame_done <= (w_state_nxt == S_DONE);
    end
  end

  assign wr_en                = !w_fifo_empty;
  assign {wr_addr, wr_data}   = r_mem[r_rd_ptr];
  assign busy                 = r_busy;
  assign frame_done           = r_frame_done;
  assign overflow             = r_overflow;
  assign max_d                = r_max_d;

endmodule

// File: doc/disp_writer.md
Name: disp_writer

Overview:
- Downstream stage of the disparity calculator.
- Captures each per-pixel disparity result `d` when the calculator pulses its result strobe, and assigns it a raster position (x, y).
- Writes {address, disparity} into the disparity-map RAM through a small FIFO, which absorbs RAM back-pressure.
- Runs a per-frame state machine and reports frame completion, overflow and the frame's maximum disparity.

Parameters:
- IMG_W, 128, pixels per row (x counter range 0..IMG_W-1).
- IMG_H, 16, rows per frame.
- DW, 6, disparity width; matches the calculator's `d` output.
- AW, 11, RAM address width; must satisfy IMG_W*IMG_H <= 2^AW.
- FIFO_DEPTH, 4, write-buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  frame start pulse; honoured only in IDLE.
- d_in  in  DW  disparity from the calculator.
- d_valid  in  1  one-cycle strobe; d_in holds a new pixel result.
- wr_ready  in  1  RAM accepts the write this cycle.
- wr_en  out  1  write request; high whenever the FIFO is non-empty.
- wr_addr  out  AW  write address = y*IMG_W + x of the head entry.
- wr_data  out  DW  disparity of the head entry.
- busy  out  1  high in RUN and DRAIN.
- frame_done  out  1  one-cycle pulse on DONE.
- overflow  out  1  sticky; a pixel was dropped because the FIFO was full.
- max_d  out  DW  running maximum of accepted disparities in the current frame.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; x=0, y=0; FIFO emptied.
  - All outputs 0. Reset mid-frame discards buffered entries and never emits frame_done.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 → RUN; clears x, y, overflow and max_d in that cycle. d_valid is ignored in IDLE.
  - RUN: each d_valid consumes one raster slot.
    - Slot address = y*IMG_W + x, computed from the registered counters.
    - x increments; at x=IMG_W-1, x wraps to 0 and y increments.
    - When the slot consumed is the last one (x=IMG_W-1, y=IMG_H-1) → DRAIN.
  - DRAIN: d_valid is ignored (no push, no overflow). FIFO empty → DONE.
  - DONE: frame_done=1 for exactly one cycle, then → IDLE.
- start while busy or in DONE: ignored.
- FIFO push: on d_valid in RUN, {addr, d} is pushed if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the pixel is dropped and overflow is set.
  - A dropped pixel still advances x/y, so later addresses stay aligned.
- FIFO pop: wr_en && wr_ready. wr_en/wr_addr/wr_data come from the registered head (show-ahead FIFO).
  - Latency: d_valid at cycle N with an empty FIFO → wr_en=1 at cycle N+1.
  - While wr_ready=0, wr_en/wr_addr/wr_data hold stable.
- max_d: updated on each accepted push with max(max_d, pushed value). Dropped pixels do not update it.
- Address arithmetic: unsigned, width AW; no wrap within a legal configuration.

Optional Feature:
- Macro: DISP_MEDIAN3_EN.
- Defined:
  - The pushed value is median(h2, h1, d_in), where h1 and h2 are the previous two disparities of the same row.
  - At x=0, h1 and h2 are loaded with d_in (so the output is d_in). At x=1, h2 is replicated from h1.
  - History updates on every d_valid in RUN, including dropped pixels.
  - Adds no latency; max_d tracks the filtered value.
- Undefined: d_in is pushed unchanged. No history registers exist.

Test Plan:
- Basic frame (IMG_W=4, IMG_H=2): start, then 8 d_valid pulses of d=1..8, with wr_ready=1 → writes addr 0..7, data 1..8, each one cycle after its strobe; frame_done pulses once after the last write; max_d=8; overflow=0.
- Back-pressure (FIFO_DEPTH=4): wr_ready=0, then 4 d_valid → FIFO full, wr_en=1 with addr 0 held stable. A 5th d_valid → dropped, overflow=1. Release wr_ready → writes addr 0,1,2,3; the next accepted pixel is written at addr 5.
- Full-FIFO push with simultaneous pop: FIFO full, wr_ready=1, d_valid=1 in the same cycle → push accepted, overflow stays 0.
- Mid-frame reset: rst_n=0 after 3 pixels → next cycle wr_en=0, busy=0, max_d=0; a new start then writes from addr 0; no frame_done from the aborted frame.
- Ignored inputs: start during RUN → counters unaffected. d_valid in IDLE or DRAIN → no write, overflow stays 0.
- DISP_MEDIAN3_EN defined, row inputs 5,0,5,5 → wr_data 5,5,5,5. Inputs 1,7,2,3 → 1,1,2,3.
